// File: rtl/maze_pkg.sv
// Shared constants and types for the maze store and its solver.
// Walls read back as 1; the solver treats 0 as passable.
package maze_pkg;
  localparam int DIM = 64;
  localparam int AW  = 6;
  localparam int CW  = 13;

  localparam logic WALL = 1'b1;
  localparam logic FREE = 1'b0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SOLVE = 2'd1,
    HALT  = 2'd2
  } state_e;
endpackage

// File: rtl/maze_load_ctrl.sv
// Phase sequencer: row load counter, load/maze ready flags,
// LOAD -> SOLVE -> HALT progression and the solved flag.
module maze_load_ctrl
  import maze_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_load_valid,
  input  logic          i_done,
  output state_e        o_state,
  output logic [AW-1:0] o_cnt,
  output logic          o_load_fire,
  output logic          o_load_ready,
  output logic          o_maze_ready,
  output logic          o_solved
);
  state_e        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_load_ready;
  logic          r_maze_ready;
  logic          r_solved;
  logic          w_fire;

  assign w_fire = (r_state == LOAD) & i_load_valid
                & r_load_ready & ~i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_cnt        <= '0;
      r_load_ready <= 1'b1;
      r_maze_ready <= 1'b0;
      r_solved     <= 1'b0;
    end else if (i_clear) begin
      r_state      <= LOAD;
      r_cnt        <= '0;
      r_load_ready <= 1'b1;
      r_maze_ready <= 1'b0;
      r_solved     <= 1'b0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (w_fire) begin
            // counter wraps to 0 on the final row
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == AW'(DIM - 1)) begin
              r_state      <= SOLVE;
              r_load_ready <= 1'b0;
              r_maze_ready <= 1'b1;
            end
          end
        end
        SOLVE: begin
          if (i_done) begin
            r_state  <= HALT;
            r_solved <= 1'b1;
          end
        end
        HALT: ;
        default: r_state <= LOAD;
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_cnt        = r_cnt;
  assign o_load_fire  = w_fire;
  assign o_load_ready = r_load_ready;
  assign o_maze_ready = r_maze_ready;
  assign o_solved     = r_solved;
endmodule

// File: rtl/maze_store.sv
// 64x64 wall/path store between the host loader and the
// wall-follower solver, with path readback and visit count.
module maze_store
  import maze_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [DIM-1:0] load_data,
  input  logic           clear,
  output logic           maze_ready,
  input  logic [AW-1:0]  row,
  input  logic [AW-1:0]  col,
  input  logic           maze_oe,
  input  logic           maze_we,
  output logic           maze_in,
  input  logic           done,
  input  logic           rd_req,
  input  logic [AW-1:0]  rd_row,
  output logic           rd_valid,
  output logic [DIM-1:0] rd_path,
  output logic [CW-1:0]  visit_cnt,
  output logic           solved
);
  state_e        w_state;
  logic [AW-1:0] w_cnt;
  logic          w_load_fire;
  logic          w_active;
  logic          w_mark;

  logic [DIM-1:0] r_wall [DIM];
  logic [DIM-1:0] r_path [DIM];
  logic           r_maze_in;
  logic           r_rd_valid;
  logic [DIM-1:0] r_rd_path;
  logic [CW-1:0]  r_visit;

  maze_load_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (clear),
    .i_load_valid (load_valid),
    .i_done       (done),
    .o_state      (w_state),
    .o_cnt        (w_cnt),
    .o_load_fire  (w_load_fire),
    .o_load_ready (load_ready),
    .o_maze_ready (maze_ready),
    .o_solved     (solved)
  );

  assign w_active = (w_state != LOAD);
  assign w_mark   = (w_state == SOLVE) & maze_we;

  // wall bitmap survives clear and reset; reload defines it
  always_ff @(posedge clk) begin
    if (w_load_fire) r_wall[w_cnt] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) r_path[i] <= '0;
      r_maze_in  <= WALL;
      r_rd_valid <= 1'b0;
      r_rd_path  <= '0;
      r_visit    <= '0;
    end else if (clear) begin
      for (int i = 0; i < DIM; i++) r_path[i] <= '0;
      r_maze_in  <= WALL;
      r_rd_valid <= 1'b0;
      r_visit    <= '0;
    end else begin
      r_rd_valid <= w_active & rd_req;
      if (w_active && rd_req) r_rd_path <= r_path[rd_row];
      if (w_active && maze_oe) r_maze_in <= r_wall[row][col];
      if (w_mark) begin
        r_path[row][col] <= 1'b1;
        if (!r_path[row][col] && r_visit != CW'(DIM * DIM))
          r_visit <= r_visit + CW'(1);
      end
    end
  end

  assign maze_in   = r_maze_in;
  assign rd_valid  = r_rd_valid;
  assign rd_path   = r_rd_path;
  assign visit_cnt = r_visit;
endmodule

// File: tb/tb_maze_store.sv
// Directed bench for maze_store with a cycle-level reference model
// and literal spot checks.
module tb_maze_store;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [63:0] load_data = '0;
  logic        clear = 1'b0;
  logic        maze_ready;
  logic [5:0]  row = '0;
  logic [5:0]  col = '0;
  logic        maze_oe = 1'b0;
  logic        maze_we = 1'b0;
  logic        maze_in;
  logic        done = 1'b0;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_row = '0;
  logic        rd_valid;
  logic [63:0] rd_path;
  logic [12:0] visit_cnt;
  logic        solved;

  int checks = 0;
  int failures = 0;

  maze_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .clear      (clear),
    .maze_ready (maze_ready),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .maze_in    (maze_in),
    .done       (done),
    .rd_req     (rd_req),
    .rd_row     (rd_row),
    .rd_valid   (rd_valid),
    .rd_path    (rd_path),
    .visit_cnt  (visit_cnt),
    .solved     (solved)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // reference model: phase 0=loading, 1=solving, 2=halted
  int          m_phase = 0;
  int          m_rows = 0;
  logic [63:0] m_wall [64];
  logic [63:0] m_path [64];
  logic        e_load_ready = 1'b1;
  logic        e_maze_ready = 1'b0;
  logic        e_maze_in = 1'b1;
  logic        e_rd_valid = 1'b0;
  logic [63:0] e_rd_path = '0;
  int          e_visit = 0;
  logic        e_solved = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_phase = 0;
      m_rows = 0;
      for (int i = 0; i < 64; i++) m_path[i] = '0;
      e_load_ready = 1'b1;
      e_maze_ready = 1'b0;
      e_maze_in = 1'b1;
      e_rd_valid = 1'b0;
      e_solved = 1'b0;
      if (!rst_n) e_rd_path = '0;
    end else begin
      e_rd_valid = 1'b0;
      if (m_phase != 0 && rd_req) begin
        e_rd_path = m_path[rd_row];
        e_rd_valid = 1'b1;
      end
      if (m_phase != 0 && maze_oe) e_maze_in = m_wall[row][col];
      if (m_phase == 1 && maze_we) m_path[row][col] = 1'b1;
      if (m_phase == 0 && load_valid) begin
        m_wall[m_rows] = load_data;
        m_rows++;
        if (m_rows == 64) begin
          m_rows = 0;
          m_phase = 1;
          e_load_ready = 1'b0;
          e_maze_ready = 1'b1;
        end
      end else if (m_phase == 1 && done) begin
        m_phase = 2;
        e_solved = 1'b1;
      end
    end
    e_visit = 0;
    for (int i = 0; i < 64; i++) e_visit += $countones(m_path[i]);
  end

  always @(negedge clk) begin
    chk("m_load_ready", 64'(load_ready), 64'(e_load_ready));
    chk("m_maze_ready", 64'(maze_ready), 64'(e_maze_ready));
    chk("m_maze_in", 64'(maze_in), 64'(e_maze_in));
    chk("m_rd_valid", 64'(rd_valid), 64'(e_rd_valid));
    chk("m_rd_path", rd_path, e_rd_path);
    chk("m_visit_cnt", 64'(visit_cnt), 64'(e_visit));
    chk("m_solved", 64'(solved), 64'(e_solved));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    load_valid = 1'b0;
    clear = 1'b0;
    maze_oe = 1'b0;
    maze_we = 1'b0;
    done = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic rd_at(int r, int c);
    idle();
    maze_oe = 1'b1;
    row = 6'(r);
    col = 6'(c);
    cyc();
  endtask

  task automatic mark(int r, int c);
    idle();
    maze_we = 1'b1;
    row = 6'(r);
    col = 6'(c);
    cyc();
  endtask

  task automatic rb(int r);
    idle();
    rd_req = 1'b1;
    rd_row = 6'(r);
    cyc();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
    chk({tag, "_maze_ready"}, 64'(maze_ready), 64'd0);
    chk({tag, "_maze_in"}, 64'(maze_in), 64'd1);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_path"}, rd_path, 64'd0);
    chk({tag, "_visit"}, 64'(visit_cnt), 64'd0);
    chk({tag, "_solved"}, 64'(solved), 64'd0);
  endtask

  initial begin
    idle();
    repeat (2) cyc();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc();

    for (int r = 0; r < 64; r++) begin
      load_valid = 1'b1;
      load_data = (r == 5) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
      cyc();
      if (r == 62) chk("ld_not_ready", 64'(maze_ready), 64'd0);
    end
    chk("ld_maze_ready", 64'(maze_ready), 64'd1);
    chk("ld_load_ready", 64'(load_ready), 64'd0);
    load_data = 64'h0;
    cyc();
    chk("ld_extra_beat", 64'(load_ready), 64'd0);

    rd_at(5, 10);
    chk("oe_5_10", 64'(maze_in), 64'd0);
    rd_at(6, 10);
    chk("oe_6_10", 64'(maze_in), 64'd1);
    rd_at(0, 10);
    chk("oe_extra_ignored", 64'(maze_in), 64'd1);
    idle();
    cyc();
    chk("oe_hold", 64'(maze_in), 64'd1);

    mark(5, 10);
    mark(5, 10);
    mark(5, 10);
    mark(5, 11);
    chk("we_visit2", 64'(visit_cnt), 64'd2);
    rb(5);
    chk("rb_valid", 64'(rd_valid), 64'd1);
    chk("rb_row5", rd_path, 64'h0000_0000_0000_0C00);
    idle();
    cyc();
    chk("rb_pulse", 64'(rd_valid), 64'd0);

    idle();
    maze_we = 1'b1;
    maze_oe = 1'b1;
    row = 6'd6;
    col = 6'd3;
    rd_req = 1'b1;
    rd_row = 6'd6;
    cyc();
    chk("same_rd_pre", rd_path, 64'h0);
    chk("same_oe_wall", 64'(maze_in), 64'd1);
    chk("same_visit3", 64'(visit_cnt), 64'd3);
    rb(6);
    chk("b2b_row6", rd_path, 64'h8);
    rb(5);
    chk("b2b_row5", rd_path, 64'h0C00);
    chk("b2b_valid", 64'(rd_valid), 64'd1);

    idle();
    maze_we = 1'b1;
    row = 6'd5;
    col = 6'd12;
    done = 1'b1;
    cyc();
    chk("done_solved", 64'(solved), 64'd1);
    chk("done_visit4", 64'(visit_cnt), 64'd4);
    mark(5, 13);
    chk("halt_we_ign", 64'(visit_cnt), 64'd4);
    rd_at(5, 13);
    chk("halt_oe", 64'(maze_in), 64'd0);
    rb(5);
    chk("halt_rb", rd_path, 64'h1C00);

    idle();
    clear = 1'b1;
    cyc();
    chk("clr_maze_ready", 64'(maze_ready), 64'd0);
    chk("clr_visit", 64'(visit_cnt), 64'd0);
    chk("clr_load_ready", 64'(load_ready), 64'd1);
    chk("clr_solved", 64'(solved), 64'd0);
    chk("clr_maze_in", 64'(maze_in), 64'd1);
    rb(5);
    chk("clr_rd_ign", 64'(rd_valid), 64'd0);

    for (int r = 0; r < 30; r++) begin
      idle();
      load_valid = 1'b1;
      load_data = 64'hF;
      cyc();
    end
    chk("part_not_ready", 64'(maze_ready), 64'd0);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int r = 0; r < 64; r++) begin
      idle();
      load_valid = 1'b1;
      load_data = 64'hF;
      cyc();
      if (r == 62) chk("rl_not_ready", 64'(maze_ready), 64'd0);
    end
    chk("rl_ready", 64'(maze_ready), 64'd1);
    rd_at(7, 4);
    chk("rl_oe_7_4", 64'(maze_in), 64'd0);
    rd_at(7, 3);
    chk("rl_oe_7_3", 64'(maze_in), 64'd1);
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
